// File: rtl/pipelined_block_adder_pkg.sv
// Sizing helpers and shared types for the pipelined block-carry adder.
package pipelined_block_adder_pkg;

  typedef logic [7:0] stage_idx_t;

  function automatic int calc_block_num(input int width, input int block_width);
    return width / block_width;
  endfunction

  function automatic int calc_stages(input int width, input int block_width, input int bps);
    return (calc_block_num(width, block_width) + bps - 1) / bps;
  endfunction

  // Exclusive upper block index handled by a stage; the last stage may be partial.
  function automatic int stage_hi_blk(input int stage, input int bps, input int block_num);
    return ((stage + 1) * bps > block_num) ? block_num : (stage + 1) * bps;
  endfunction

  function automatic bit params_ok(input int width, input int block_width, input int bps);
    return (block_width > 0) && (bps >= 1) && (width >= block_width) &&
           ((width % block_width) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline stage: resolves its slice of blocks with p_all/g_all carry anticipation
// and registers operands, partial sum, carry and valid. Optional ADDER_OVF_EN overflow bit.
module pipe_adder_stage
  import pipelined_block_adder_pkg::*;
#(
  parameter int         WIDTH            = 32,
  parameter int         BLOCK_WIDTH      = 4,
  parameter int         BLOCKS_PER_STAGE = 2,
  parameter stage_idx_t STAGE            = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BLOCK_NUM = calc_block_num(WIDTH, BLOCK_WIDTH);
  localparam int LO_BLK    = int'(STAGE) * BLOCKS_PER_STAGE;
  localparam int HI_BLK    = stage_hi_blk(int'(STAGE), BLOCKS_PER_STAGE, BLOCK_NUM);

  logic [WIDTH-1:0] sum_nxt;
  logic             carry_nxt;
  logic             p_all, g_all, bit_c, p, g;
`ifdef ADDER_OVF_EN
  logic             msb_cin;
`endif

  always_comb begin
    sum_nxt   = prev_sum;
    carry_nxt = prev_carry;
    p_all     = 1'b1;
    g_all     = 1'b0;
    bit_c     = 1'b0;
    p         = 1'b0;
    g         = 1'b0;
`ifdef ADDER_OVF_EN
    msb_cin   = 1'b0;
`endif
    for (int blk = LO_BLK; blk < HI_BLK; blk++) begin
      p_all = 1'b1;
      g_all = 1'b0;
      bit_c = carry_nxt;
      for (int j = 0; j < BLOCK_WIDTH; j++) begin
        p = prev_a[blk*BLOCK_WIDTH+j] ^ prev_b[blk*BLOCK_WIDTH+j];
        g = prev_a[blk*BLOCK_WIDTH+j] & prev_b[blk*BLOCK_WIDTH+j];
        sum_nxt[blk*BLOCK_WIDTH+j] = p ^ bit_c;
`ifdef ADDER_OVF_EN
        if (blk * BLOCK_WIDTH + j == WIDTH - 1) msb_cin = bit_c;
`endif
        bit_c = g | (p & bit_c);
        g_all = g | (p & g_all);
        p_all = p_all & p;
      end
      // Block carry-out comes from the anticipation terms, not the ripple.
      carry_nxt = g_all | (p_all & carry_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      valid <= prev_valid;
      a     <= prev_a;
      b     <= prev_b;
      sum   <= sum_nxt;
      carry <= carry_nxt;
`ifdef ADDER_OVF_EN
      ovf   <= msb_cin ^ carry_nxt;
`endif
    end
  end

endmodule

// File: rtl/pipelined_block_adder.sv
// Pipelined block-carry adder/subtractor with valid/ready handshake and skewed stages.
// Define ADDER_OVF_EN to add the signed-overflow output out_ovf.
module pipelined_block_adder
  import pipelined_block_adder_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK_WIDTH      = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);

  if (!params_ok(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE)) begin : g_param_check
    $error("pipelined_block_adder: WIDTH must be a multiple of BLOCK_WIDTH and BLOCKS_PER_STAGE >= 1");
  end

  // Index 0 is the operand port; index k+1 is the register output of stage k.
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  carry_c;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] a_c   [STAGES+1];
  logic [WIDTH-1:0] b_c   [STAGES+1];
  logic [WIDTH-1:0] sum_c [STAGES+1];
`ifdef ADDER_OVF_EN
  logic [STAGES-1:0] ovf_c;
`endif

  assign valid_c[0] = in_valid;
  assign a_c[0]     = in_a;
  assign b_c[0]     = in_sub ? ~in_b : in_b;
  assign carry_c[0] = in_sub | in_cin;
  assign sum_c[0]   = '0;

  // Ready ripples back from the output; a stage with no valid beat is always free.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid_c[k+1] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0] | rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(
      .WIDTH            (WIDTH),
      .BLOCK_WIDTH      (BLOCK_WIDTH),
      .BLOCKS_PER_STAGE (BLOCKS_PER_STAGE),
      .STAGE            (stage_idx_t'(k))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .load       (rdy[k]),
      .prev_valid (valid_c[k]),
      .prev_a     (a_c[k]),
      .prev_b     (b_c[k]),
      .prev_sum   (sum_c[k]),
      .prev_carry (carry_c[k]),
      .valid      (valid_c[k+1]),
      .a          (a_c[k+1]),
      .b          (b_c[k+1]),
      .sum        (sum_c[k+1]),
      .carry      (carry_c[k+1])
`ifdef ADDER_OVF_EN
      ,
      .ovf        (ovf_c[k])
`endif
    );
  end

  assign out_valid = valid_c[STAGES];
  assign out_sum   = sum_c[STAGES];
  assign out_cout  = carry_c[STAGES];
`ifdef ADDER_OVF_EN
  assign out_ovf   = ovf_c[STAGES-1];
`endif

  // Operands are fully consumed by the last stage; earlier overflow bits are don't-care.
  logic unused_tail;
`ifdef ADDER_OVF_EN
  assign unused_tail = ^{a_c[STAGES], b_c[STAGES], ovf_c};
`else
  assign unused_tail = ^{a_c[STAGES], b_c[STAGES]};
`endif

endmodule

// File: tb/tb_pipelined_block_adder.sv
// Scoreboard bench for pipelined_block_adder: directed steps plus a negedge output monitor.
module tb_pipelined_block_adder;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADDER_OVF_EN
  logic         out_ovf;
`endif

  int   errors  = 0;
  int   checks  = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipelined_block_adder #(
    .WIDTH            (W),
    .BLOCK_WIDTH      (4),
    .BLOCKS_PER_STAGE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   full;
    exp_t         e;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk1("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk1(tag, out_valid, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      run_len = 0;
    end else begin
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_cin, in_sub));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk1("unexpected_out", out_valid, 1'b0);
        end else begin
          e = sb[0];
          chk("sb_sum", out_sum, e.sum);
          chk1("sb_cout", out_cout, e.cout);
`ifdef ADDER_OVF_EN
          chk1("sb_ovf", out_ovf, e.ovf);
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (out_valid && out_ready) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk1("rst_out_cout", out_cout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);

    // 1: carry through all blocks, latency
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_sub = 1'b0;
    @(negedge clk);
    chk1("t1_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk1("t1_not_early", out_valid, 1'b0);
    @(negedge clk);
    chk1("t1_latency4", out_valid, 1'b1);
    chk("t1_sum", out_sum, 32'h0000_0000);
    chk1("t1_cout", out_cout, 1'b1);

    // 2: subtraction both directions
    @(posedge clk);
    #1;
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'd7, 32'd5, 1'b0, 1'b1);
    wait_out("t2_valid0");
    chk("t2_sum0", out_sum, 32'hFFFF_FFFE);
    chk1("t2_cout0", out_cout, 1'b0);
    @(negedge clk);
    chk1("t2_valid1", out_valid, 1'b1);
    chk("t2_sum1", out_sum, 32'h0000_0002);
    chk1("t2_cout1", out_cout, 1'b1);

    // 3: 16 back-to-back random beats
    repeat (6) @(posedge clk);
    #1;
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (10) @(negedge clk);
    chk("t3_consecutive", W'(max_run), 32'd16);
    chk("t3_drained", W'(sb.size()), 32'd0);

    // 4: stall with out_ready low for 6 cycles
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h8765_4321; in_cin = 1'b1; in_sub = 1'b0;
    @(negedge clk);
    chk1("t4_full_in_ready", in_ready, 1'b0);
    chk1("t4_full_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("t4_full_in_ready2", in_ready, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (10) @(negedge clk);
    chk("t4_drained", W'(sb.size()), 32'd0);

    // 5: reset with 3 beats in flight
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      send($urandom(), $urandom(), 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk1("t5_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_out_valid", out_valid, 1'b0);
    chk1("t5_in_ready", in_ready, 1'b1);
    chk("t5_out_sum", out_sum, '0);
    chk1("t5_out_cout", out_cout, 1'b0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    send(32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("t5_drained", W'(sb.size()), 32'd0);

`ifdef ADDER_OVF_EN
    // 6: signed overflow
    @(posedge clk);
    #1;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    wait_out("t6_valid0");
    chk1("t6_ovf_add", out_ovf, 1'b1);
    @(negedge clk);
    chk1("t6_ovf_sub", out_ovf, 1'b1);
    @(negedge clk);
    chk1("t6_ovf_none", out_ovf, 1'b0);
    repeat (6) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
